// File: rtl/efc_transition_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : efc_transition_scheduler
// Description : Picks one enabled, requested Petri-net transition (t0..t6)
//               at a time. It issues a one-cycle one-hot fire/ack pulse and
//               then waits SETTLE_CYCLES cycles so the three FSMs can update
//               their markings. It also tracks the hidden FSM2 places p3 and
//               p5 with shadow bits, flags long-blocked requests and flags
//               inconsistent marking inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module efc_transition_scheduler #(
    parameter int SETTLE_CYCLES = 1,   // 1..15
    parameter int STALL_LIMIT   = 64   // 2..255
) (
    input  logic       clk,
    input  logic       reset,          // asynchronous, active-low
    input  logic [6:0] req,
    input  logic [3:0] f1_mark,        // {p6,p0,p4,p2}
    input  logic [1:0] f2_mark,        // {p0,p7}
    input  logic [3:0] f3_mark,        // {p1,p6,p4,p2}
    output logic [6:0] fire,
    output logic [6:0] ack,
    output logic       busy,
    output logic       stall,
    output logic       mark_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRE   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    // The settle counter is loaded with SETTLE_CYCLES-1. SETTLE then exits
    // when the counter reaches zero, so SETTLE lasts exactly SETTLE_CYCLES
    // cycles.
    localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] c_STALL_LIMIT = 8'(STALL_LIMIT);

    state_t     r_state;
    state_t     w_state_next;
    logic [6:0] r_sel;            // one-hot transition latched for FIRE
    logic [3:0] r_settle_cnt;
    logic       r_rr;             // t0/t1 arbitration: 0 -> t0 next
    logic       r_sh3;            // shadow of FSM2 p3 (set by t0)
    logic       r_sh5;            // shadow of FSM2 p5 (set by t1)
    logic [7:0] r_stall_cnt;
    logic       r_stall;
    logic       r_mark_err;

    logic [6:0] w_enabled;
    logic [6:0] w_cand;
    logic [6:0] w_pick;
    logic       w_blocked;
    logic [7:0] w_stall_inc;
    logic       w_mark_bad;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Enabledness of each transition from the exported markings and shadows.
    always_comb begin
        w_enabled    = '0;
        w_enabled[0] = f1_mark[2] & f2_mark[1] & f3_mark[3];
        w_enabled[1] = f1_mark[2] & f2_mark[1] & f3_mark[3];
        w_enabled[2] = f1_mark[0] & f3_mark[0];
        w_enabled[3] = r_sh3;
        w_enabled[4] = f1_mark[1] & f3_mark[1];
        w_enabled[5] = r_sh5;
        w_enabled[6] = f1_mark[3] & f2_mark[0] & f3_mark[2];
    end

    // Candidate set and winner selection. Only IDLE considers requests.
    // Among the other candidates the lowest index wins. When t0 and t1
    // compete, the round-robin bit decides between them.
    always_comb begin
        w_cand = (r_state == ST_IDLE) ? (req & w_enabled) : 7'd0;
        if (w_cand[0] && w_cand[1]) begin
            w_pick = r_rr ? 7'b000_0010 : 7'b000_0001;
        end else begin
            w_pick = w_cand & (~w_cand + 7'd1);
        end
    end

    // Stall and marking-consistency conditions, meaningful only in IDLE.
    always_comb begin
        w_blocked   = (r_state == ST_IDLE) && (req != 7'd0) && (w_cand == 7'd0);
        w_stall_inc = (r_stall_cnt == 8'hFF) ? r_stall_cnt : (r_stall_cnt + 8'd1);
        w_mark_bad  = (r_state == ST_IDLE) &&
                      (!is_onehot4(f1_mark) || (&f2_mark) || !is_onehot4(f3_mark));
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and outputs. Reset forces IDLE, which drops
    // fire/ack/busy at once.
    always_comb begin
        w_state_next = r_state;
        fire         = '0;
        ack          = '0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cand != 7'd0) begin
                    w_state_next = ST_FIRE;
                end
            end
            ST_FIRE: begin
                fire         = r_sel;
                ack          = r_sel;
                busy         = 1'b1;
                w_state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (r_settle_cnt == 4'd0) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Latch the winner and run the settle down-counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel        <= '0;
            r_settle_cnt <= '0;
        end else begin
            if (w_cand != 7'd0) begin
                r_sel <= w_pick;
            end
            if (r_state == ST_FIRE) begin
                r_settle_cnt <= c_SETTLE_LOAD;
            end else if ((r_state == ST_SETTLE) && (r_settle_cnt != 4'd0)) begin
                r_settle_cnt <= r_settle_cnt - 4'd1;
            end
        end
    end

    // Shadow places and round-robin bit update on the firing cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sh3 <= 1'b0;
            r_sh5 <= 1'b0;
            r_rr  <= 1'b0;
        end else if (r_state == ST_FIRE) begin
            if (r_sel[0]) begin
                r_sh3 <= 1'b1;
            end else if (r_sel[3]) begin
                r_sh3 <= 1'b0;
            end
            if (r_sel[1]) begin
                r_sh5 <= 1'b1;
            end else if (r_sel[5]) begin
                r_sh5 <= 1'b0;
            end
            if (r_sel[0] || r_sel[1]) begin
                r_rr <= ~r_rr;
            end
        end
    end

    // Saturating blocked-request counter and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_stall     <= 1'b0;
            r_mark_err  <= 1'b0;
        end else begin
            if (w_blocked) begin
                r_stall_cnt <= w_stall_inc;
                if (w_stall_inc >= c_STALL_LIMIT) begin
                    r_stall <= 1'b1;
                end
            end else begin
                r_stall_cnt <= '0;
            end
            if (w_mark_bad) begin
                r_mark_err <= 1'b1;
            end
        end
    end

    assign stall    = r_stall;
    assign mark_err = r_mark_err;

endmodule
`default_nettype wire

// File: tb/tb_efc_transition_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_efc_transition_scheduler
// Description : Scoreboard bench for efc_transition_scheduler. Stimulus
//               pushes the expected fire vectors into a queue. A monitor
//               pops and compares them whenever fire/ack is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_efc_transition_scheduler;

    localparam int c_SETTLE = 2;
    localparam int c_LIMIT  = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] req = '0;
    logic [3:0] f1_mark = 4'b0100;
    logic [1:0] f2_mark = 2'b10;
    logic [3:0] f3_mark = 4'b1000;
    logic [6:0] fire, ack;
    logic       busy, stall, mark_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [6:0] exp_q[$];

    efc_transition_scheduler #(
        .SETTLE_CYCLES(c_SETTLE),
        .STALL_LIMIT  (c_LIMIT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .f1_mark (f1_mark),
        .f2_mark (f2_mark),
        .f3_mark (f3_mark),
        .fire    (fire),
        .ack     (ack),
        .busy    (busy),
        .stall   (stall),
        .mark_err(mark_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every observed firing is compared with the oldest expectation.
    always @(negedge clk) begin
        logic [6:0] e;
        if (reset && ((fire != 7'd0) || (ack != 7'd0))) begin
            check("fire_onehot", {31'd0, $onehot(fire)}, 32'd1);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_fire: got %0h expected none", fire);
            end else begin
                e = exp_q.pop_front();
                check("fire_value", {25'd0, fire}, {25'd0, e});
                check("ack_value", {25'd0, ack}, {25'd0, e});
            end
        end
    end

    // Returns the number of negedges until fire is seen (bounded).
    task automatic wait_fire(output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n = i + 1;
            if (fire != 7'd0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL fire_timeout: got no fire expected a firing");
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
    endtask

    // Drive one request, check its latency and the length of the busy window.
    task automatic do_fire(input logic [6:0] r, input logic [6:0] e);
        int  lat;
        int  nb;
        bit  ok;
        exp_q.push_back(e);
        @(posedge clk);
        #1 req = r;
        wait_fire(lat, ok);
        req = 7'd0;
        // The drive lands after an edge. The next edge evaluates the request,
        // and fire is then seen on the following negedge.
        check("latency", lat, 2);
        if (ok) begin
            nb = 1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (!busy) break;
                nb++;
            end
            check("busy_len", nb, 1 + c_SETTLE);
        end
        wait_idle();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic count_fires(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (fire != 7'd0) n++;
        end
    endtask

    initial begin
        int  lat;
        int  nf;
        bit  ok;

        // Reset state.
        #2;
        check("rst_fire", {25'd0, fire}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_mark_err", {31'd0, mark_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Single t0 firing.
        do_fire(7'h01, 7'h01);

        // Held t0/t1 request alternates starting from t0 after reset.
        do_reset();
        exp_q.push_back(7'h01);
        exp_q.push_back(7'h02);
        exp_q.push_back(7'h01);
        @(posedge clk);
        #1 req = 7'h03;
        wait_fire(lat, ok);
        wait_fire(lat, ok);
        check("rr_spacing1", lat, 2 + c_SETTLE);
        wait_fire(lat, ok);
        check("rr_spacing2", lat, 2 + c_SETTLE);
        req = 7'd0;
        wait_idle();

        // sh3 is set: t2 wins over t3, then t3 fires and clears sh3.
        @(posedge clk);
        #1 f1_mark = 4'b0001;
        f3_mark = 4'b0001;
        exp_q.push_back(7'h04);
        exp_q.push_back(7'h08);
        req = 7'h0C;
        wait_fire(lat, ok);
        req = 7'h08;
        wait_fire(lat, ok);
        check("t3_spacing", lat, 2 + c_SETTLE);
        req = 7'd0;
        wait_idle();
        @(posedge clk);
        #1 req = 7'h08;
        count_fires(8, nf);
        check("sh3_cleared", nf, 0);
        req = 7'd0;

        // t5 through sh5 (set by the earlier t1), then t4 and t6.
        do_fire(7'h20, 7'h20);
        @(posedge clk);
        #1 f1_mark = 4'b0010;
        f3_mark = 4'b0010;
        do_fire(7'h10, 7'h10);
        @(posedge clk);
        #1 f1_mark = 4'b1000;
        f2_mark = 2'b01;
        f3_mark = 4'b0100;
        do_fire(7'h40, 7'h40);
        check("no_mark_err", {31'd0, mark_err}, 32'd0);

        // Blocked t6 request raises stall after exactly STALL_LIMIT cycles.
        do_reset();
        @(posedge clk);
        #1 f1_mark = 4'b0100;
        f2_mark = 2'b10;
        f3_mark = 4'b1000;
        req = 7'h40;
        repeat (c_LIMIT - 1) @(posedge clk);
        @(negedge clk);
        check("stall_before", {31'd0, stall}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("stall_at_limit", {31'd0, stall}, 32'd1);
        req = 7'd0;
        repeat (3) @(negedge clk);
        check("stall_sticky", {31'd0, stall}, 32'd1);

        // Inconsistent FSM1 marking sets sticky mark_err.
        check("mark_err_before", {31'd0, mark_err}, 32'd0);
        @(posedge clk);
        #1 f1_mark = 4'b0011;
        @(posedge clk);
        @(negedge clk);
        check("mark_err_set", {31'd0, mark_err}, 32'd1);
        f1_mark = 4'b0100;
        repeat (5) @(negedge clk);
        check("mark_err_sticky", {31'd0, mark_err}, 32'd1);

        // Reset during FIRE truncates the pulse; nothing is replayed.
        do_reset();
        check("reset_clears_stall", {31'd0, stall}, 32'd0);
        check("reset_clears_mark_err", {31'd0, mark_err}, 32'd0);
        exp_q.push_back(7'h01);
        @(posedge clk);
        #1 req = 7'h01;
        wait_fire(lat, ok);
        #1 reset = 1'b0;
        #1;
        check("async_fire", {25'd0, fire}, 32'd0);
        check("async_ack", {25'd0, ack}, 32'd0);
        check("async_busy", {31'd0, busy}, 32'd0);
        req = 7'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        count_fires(6, nf);
        check("no_replay", nf, 0);
        // The interrupted t0 must not have toggled rr: t0 wins first again.
        do_fire(7'h03, 7'h01);

        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
